// File: rtl/nanorv32_alu_arb_pkg.sv
// Shared constants for the nanorv32 ALU arbiter: data/op widths, ALU op codes
// and the local response-FSM state encoding.
package nanorv32_alu_arb_pkg;

  localparam int NANORV32_DATA_MSB           = 31;
  localparam int NANORV32_MUX_SEL_ALU_OP_MSB = 3;

  typedef logic [NANORV32_MUX_SEL_ALU_OP_MSB:0] alu_op_t;

  localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_ADD         = 4'd0;
  localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_SUB         = 4'd1;
  localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_AND         = 4'd2;
  localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_OR          = 4'd3;
  localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_XOR         = 4'd4;
  localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_SLL         = 4'd5;
  localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_SRL         = 4'd6;
  localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_SRA         = 4'd7;
  localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_LT_SIGNED   = 4'd8;
  localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_LT_UNSIGNED = 4'd9;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_RESP = 1'b1;

endpackage

// File: rtl/nanorv32_alu.sv
// Combinational nanorv32 ALU: one result per op code plus the reduction-OR
// condition flag used by branch/compare consumers.
module nanorv32_alu
  import nanorv32_alu_arb_pkg::*;
#(
  parameter int DATA_W = NANORV32_DATA_MSB + 1,
  parameter int OP_W   = NANORV32_MUX_SEL_ALU_OP_MSB + 1
) (
  input  logic [DATA_W-1:0] porta,
  input  logic [DATA_W-1:0] portb,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] alu_res,
  output logic              alu_cond
);

  localparam int SHAMT_W = $clog2(DATA_W);

  logic [SHAMT_W-1:0] shamt;
  assign shamt = portb[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      NANORV32_MUX_SEL_ALU_OP_ADD:         alu_res = porta + portb;
      NANORV32_MUX_SEL_ALU_OP_SUB:         alu_res = porta - portb;
      NANORV32_MUX_SEL_ALU_OP_AND:         alu_res = porta & portb;
      NANORV32_MUX_SEL_ALU_OP_OR:          alu_res = porta | portb;
      NANORV32_MUX_SEL_ALU_OP_XOR:         alu_res = porta ^ portb;
      NANORV32_MUX_SEL_ALU_OP_SLL:         alu_res = porta << shamt;
      NANORV32_MUX_SEL_ALU_OP_SRL:         alu_res = porta >> shamt;
      NANORV32_MUX_SEL_ALU_OP_SRA:         alu_res = $signed(porta) >>> shamt;
      NANORV32_MUX_SEL_ALU_OP_LT_SIGNED:
        alu_res = {{(DATA_W-1){1'b0}}, ($signed(porta) < $signed(portb))};
      NANORV32_MUX_SEL_ALU_OP_LT_UNSIGNED:
        alu_res = {{(DATA_W-1){1'b0}}, (porta < portb)};
      default:                             alu_res = '0;
    endcase
  end

  assign alu_cond = |alu_res;

endmodule

// File: rtl/nanorv32_alu_arb.sv
// Round-robin arbiter sharing one nanorv32_alu between two requesters, with a
// one-deep registered response per accepted operation.
module nanorv32_alu_arb
  import nanorv32_alu_arb_pkg::*;
#(
  parameter int DATA_W = NANORV32_DATA_MSB + 1,
  parameter int OP_W   = NANORV32_MUX_SEL_ALU_OP_MSB + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_porta,
  input  logic [DATA_W-1:0] req0_portb,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_porta,
  input  logic [DATA_W-1:0] req1_portb,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_res,
  output logic              rsp_cond,
  output logic              owner
);

  logic              state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] rsp_res_q, rsp_res_d;
  logic              rsp_cond_q, rsp_cond_d;

  logic              grant_valid;
  logic              grant;
  logic              release_rsp;
  logic              can_accept;
  logic              accept;

  logic [DATA_W-1:0] alu_porta, alu_portb, alu_res;
  logic [OP_W-1:0]   alu_op;
  logic              alu_cond;

  // Readies are purely combinational so a held response can be released and
  // replaced in the same cycle.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant       = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    release_rsp = (state_q == STATE_RESP) & (owner_q ? rsp1_ready : rsp0_ready);
    can_accept  = (state_q == STATE_IDLE) | release_rsp;
    accept      = can_accept & grant_valid & rst_n;
  end

  assign req0_ready = accept & ~grant;
  assign req1_ready = accept & grant;

  assign alu_porta = grant ? req1_porta : req0_porta;
  assign alu_portb = grant ? req1_portb : req0_portb;
  assign alu_op    = grant ? req1_op    : req0_op;

  nanorv32_alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .porta    (alu_porta),
    .portb    (alu_portb),
    .op       (alu_op),
    .alu_res  (alu_res),
    .alu_cond (alu_cond)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rsp_res_d    = rsp_res_q;
    rsp_cond_d   = rsp_cond_q;
    if (accept) begin
      state_d      = STATE_RESP;
      owner_d      = grant;
      last_grant_d = grant;
      rsp_res_d    = alu_res;
      rsp_cond_d   = alu_cond;
    end else if (release_rsp) begin
      state_d = STATE_IDLE;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= STATE_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_res_q    <= '0;
      rsp_cond_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rsp_res_q    <= rsp_res_d;
      rsp_cond_q   <= rsp_cond_d;
    end
  end

  assign rsp0_valid = (state_q == STATE_RESP) & ~owner_q;
  assign rsp1_valid = (state_q == STATE_RESP) & owner_q;
  assign rsp_res    = rsp_res_q;
  assign rsp_cond   = rsp_cond_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_nanorv32_alu_arb.sv
// Directed bench for nanorv32_alu_arb: a vector table of single operations
// followed by conflict, backpressure, streaming and mid-operation reset cases.
module tb_nanorv32_alu_arb;
  import nanorv32_alu_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_porta, req0_portb, req1_porta, req1_portb;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_res;
  logic        rsp_cond;
  logic        owner;

  int n_total;
  int n_pass;

  nanorv32_alu_arb #(
    .DATA_W (32),
    .OP_W   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_porta (req0_porta),
    .req0_portb (req0_portb),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_porta (req1_porta),
    .req1_portb (req1_portb),
    .req1_op    (req1_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_res    (rsp_res),
    .rsp_cond   (rsp_cond),
    .owner      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cond;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("check %-24s act=%08h exp=%08h ok", name, act, exp);
    end else begin
      $display("FAIL %-24s act=%08h exp=%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    if (sel) begin
      req1_valid = 1'b1; req1_op = op; req1_porta = a; req1_portb = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_porta = a; req0_portb = b;
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    vecs[0]  = '{1'b0, NANORV32_MUX_SEL_ALU_OP_ADD,         32'd5,        32'd7,   32'd12,        1'b1};
    vecs[1]  = '{1'b1, NANORV32_MUX_SEL_ALU_OP_SUB,         32'd3,        32'd3,   32'd0,         1'b0};
    vecs[2]  = '{1'b0, NANORV32_MUX_SEL_ALU_OP_LT_SIGNED,   32'hFFFFFFFF, 32'd1,   32'd1,         1'b1};
    vecs[3]  = '{1'b1, NANORV32_MUX_SEL_ALU_OP_LT_UNSIGNED, 32'hFFFFFFFF, 32'd1,   32'd0,         1'b0};
    vecs[4]  = '{1'b0, NANORV32_MUX_SEL_ALU_OP_AND,         32'h0000F0F0, 32'hFF00, 32'h0000F000, 1'b1};
    vecs[5]  = '{1'b1, NANORV32_MUX_SEL_ALU_OP_OR,          32'h0F,       32'hF0,  32'hFF,        1'b1};
    vecs[6]  = '{1'b0, NANORV32_MUX_SEL_ALU_OP_XOR,         32'hF0,       32'hFF,  32'h0F,        1'b1};
    vecs[7]  = '{1'b1, NANORV32_MUX_SEL_ALU_OP_SLL,         32'd1,        32'd31,  32'h80000000,  1'b1};
    vecs[8]  = '{1'b0, NANORV32_MUX_SEL_ALU_OP_SRL,         32'h80000000, 32'd4,   32'h08000000,  1'b1};
    vecs[9]  = '{1'b1, NANORV32_MUX_SEL_ALU_OP_SRA,         32'h80000000, 32'd4,   32'hF8000000,  1'b1};
    vecs[10] = '{1'b0, NANORV32_MUX_SEL_ALU_OP_ADD,         32'hFFFFFFFF, 32'd1,   32'd0,         1'b0};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_porta = '0; req0_portb = '0; req0_op = '0;
    req1_porta = '0; req1_portb = '0; req1_op = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset state, including readies forced low while a request is pending.
    repeat (2) @(negedge clk);
    req0_valid = 1'b1;
    #1;
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp_res", rsp_res, 32'd0);
    chk("rst_rsp_cond", 32'(rsp_cond), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one isolated operation per vector.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("v%0d_req_ready", i),
          32'(vecs[i].sel ? req1_ready : req0_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", i),
          32'(vecs[i].sel ? rsp1_valid : rsp0_valid), 32'd1);
      chk($sformatf("v%0d_other_valid", i),
          32'(vecs[i].sel ? rsp0_valid : rsp1_valid), 32'd0);
      chk($sformatf("v%0d_res", i), rsp_res, vecs[i].res);
      chk($sformatf("v%0d_cond", i), 32'(rsp_cond), 32'(vecs[i].cond));
      chk($sformatf("v%0d_owner", i), 32'(owner), 32'(vecs[i].sel));
      req0_valid = 1'b0; req1_valid = 1'b0;
    end

    // Reset for a clean round-robin history, then conflict.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b0, NANORV32_MUX_SEL_ALU_OP_ADD, 32'd1, 32'd1);
    drive(1'b1, NANORV32_MUX_SEL_ALU_OP_ADD, 32'd2, 32'd2);
    #1;
    chk("cf_req0_ready", 32'(req0_ready), 32'd1);
    chk("cf_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    chk("cf_first_owner", 32'(owner), 32'd0);
    chk("cf_first_res", rsp_res, 32'd2);
    req0_valid = 1'b0;
    #1;
    chk("cf_req1_ready_b2b", 32'(req1_ready), 32'd1);
    @(negedge clk);
    chk("cf_second_owner", 32'(owner), 32'd1);
    chk("cf_second_res", rsp_res, 32'd4);
    chk("cf_second_valid", 32'(rsp1_valid), 32'd1);

    drive(1'b0, NANORV32_MUX_SEL_ALU_OP_ADD, 32'd10, 32'd1);
    drive(1'b1, NANORV32_MUX_SEL_ALU_OP_ADD, 32'd20, 32'd2);
    for (int k = 0; k < 4; k++) begin
      logic exp_g;
      exp_g = (k % 2 == 1);
      #1;
      chk($sformatf("rr%0d_req0_ready", k), 32'(req0_ready), 32'(!exp_g));
      chk($sformatf("rr%0d_req1_ready", k), 32'(req1_ready), 32'(exp_g));
      @(negedge clk);
      chk($sformatf("rr%0d_owner", k), 32'(owner), 32'(exp_g));
      chk($sformatf("rr%0d_res", k), rsp_res, exp_g ? 32'd22 : 32'd11);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure on requester 0 blocks requester 1.
    @(negedge clk);
    @(negedge clk);
    rsp0_ready = 1'b0;
    drive(1'b0, NANORV32_MUX_SEL_ALU_OP_XOR, 32'hF0, 32'hFF);
    #1;
    chk("bp_req0_ready", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    drive(1'b1, NANORV32_MUX_SEL_ALU_OP_ADD, 32'd3, 32'd4);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d_rsp0_valid", i), 32'(rsp0_valid), 32'd1);
      chk($sformatf("bp%0d_res", i), rsp_res, 32'h0F);
      chk($sformatf("bp%0d_req1_ready", i), 32'(req1_ready), 32'd0);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    #1;
    chk("bp_release_req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    chk("bp_req1_owner", 32'(owner), 32'd1);
    chk("bp_req1_valid", 32'(rsp1_valid), 32'd1);
    chk("bp_rsp0_dropped", 32'(rsp0_valid), 32'd0);
    chk("bp_req1_res", rsp_res, 32'd7);
    req1_valid = 1'b0;

    // Streaming: eight back-to-back ADDs with no idle gap.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, NANORV32_MUX_SEL_ALU_OP_ADD, 32'(i), 32'd100);
      #1;
      chk($sformatf("st%0d_req0_ready", i), 32'(req0_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("st%0d_rsp0_valid", i), 32'(rsp0_valid), 32'd1);
      chk($sformatf("st%0d_res", i), rsp_res, 32'(i + 100));
    end
    req0_valid = 1'b0;

    // Asynchronous reset while a response is held.
    @(negedge clk);
    @(negedge clk);
    rsp1_ready = 1'b0;
    drive(1'b1, NANORV32_MUX_SEL_ALU_OP_ADD, 32'd5, 32'd5);
    @(negedge clk);
    req1_valid = 1'b0;
    chk("ar_rsp1_valid_before", 32'(rsp1_valid), 32'd1);
    chk("ar_res_before", rsp_res, 32'd10);
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    chk("ar_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("ar_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("ar_res", rsp_res, 32'd0);
    chk("ar_owner", 32'(owner), 32'd0);
    chk("ar_req0_ready", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    rsp1_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, NANORV32_MUX_SEL_ALU_OP_SUB, 32'd9, 32'd4);
    drive(1'b1, NANORV32_MUX_SEL_ALU_OP_SUB, 32'd8, 32'd1);
    #1;
    chk("ar_cf_req0_ready", 32'(req0_ready), 32'd1);
    chk("ar_cf_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    chk("ar_cf_owner", 32'(owner), 32'd0);
    chk("ar_cf_res", rsp_res, 32'd5);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
